pixel_streamer: RTL and testbench
=================================

PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 Parameter I_F_BW, default 8, pixel width in bits.
REQ-002 Parameter IX, default 28, image width in pixels.
REQ-003 Parameter IY, default 28, image height in pixels.
REQ-004 Port clk, input, 1, single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port i_start, input, 1, frame start request, sampled in IDLE only.
REQ-007 Port o_busy, output, 1, high from start acceptance until the o_done cycle, inclusive.
REQ-008 Port o_done, output, 1, one-cycle pulse after the last pixel handshake.
REQ-009 Port o_mem_en, output, 1, image memory read enable.
REQ-010 Port o_mem_addr, output, clog2(IX*IY), image memory read address, row-major.
REQ-011 Port i_mem_data, input, I_F_BW, read data, valid exactly 1 cycle after o_mem_en.
REQ-012 Port o_valid, output, 1, pixel stream valid to the line buffer / convolution input.
REQ-013 Port o_pixel, output, I_F_BW, pixel data.
REQ-014 Port i_ready, input, 1, downstream ready; a transfer occurs when o_valid and i_ready are both high.
REQ-015 Port o_row, output, clog2(IY), row index of the current o_pixel.
REQ-016 Port o_col, output, clog2(IX), column index of the current o_pixel.
REQ-017 Port o_last, output, 1, high with o_valid for pixel IX*IY-1 only.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN and DONE; DONE SHALL last exactly 1 cycle.
REQ-019 IDLE to RUN SHALL occur on i_start=1; i_start SHALL be ignored in every other state.
REQ-020 In RUN, a read SHALL be issued (o_mem_en=1, addr incremented after issue) only when outstanding reads plus buffer occupancy are below 2.
REQ-021 RUN to DRAIN SHALL occur when read address IX*IY-1 is issued; DRAIN to DONE SHALL occur on the handshake with o_last=1.
REQ-022 Read data SHALL be written into a 2-entry FIFO; o_valid SHALL equal FIFO non-empty, and o_pixel SHALL be the FIFO head.
REQ-023 Latency: with i_ready held at 1, first o_mem_en SHALL be in cycle S+1 and first o_valid in cycle S+3, where S is the i_start sampling edge.
REQ-024 Throughput: with i_ready held at 1, all IX*IY pixels SHALL be transferred in IX*IY consecutive cycles.
REQ-025 While o_valid=1 and i_ready=0, o_pixel, o_row, o_col and o_last SHALL hold stable, and no pixel SHALL be dropped or duplicated.
REQ-026 o_col SHALL wrap from IX-1 to 0 on a handshake and then increment o_row; o_row and o_col SHALL advance on handshakes only.
REQ-027 On a simultaneous FIFO write and read while the FIFO is full, the read SHALL retire first and the write SHALL be accepted.
REQ-028 o_done SHALL pulse in the cycle after the final handshake; o_busy SHALL fall in the following cycle.
REQ-029 A new i_start SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-030 Reset SHALL force IDLE and clear the FIFO and all counters, aborting any frame in progress; the data returned for an in-flight read SHALL be discarded.
REQ-031 During and after reset, o_busy, o_done, o_mem_en, o_valid, o_last, o_mem_addr, o_pixel, o_row and o_col SHALL all be 0.

Structure
REQ-032 The FSM state enum and the default I_F_BW/IX/IY constants SHALL reside in the shared CNN package.
REQ-033 The 2-entry FIFO SHALL be a separate sub-module named pixel_skid_fifo, with write/read/full/empty signals.

Verification
REQ-034 Memory preloaded with (addr+1) mod 256, i_ready=1, pulse i_start -> pixels 1..255,0,1,… appear in 784 consecutive cycles; o_last on pixel 784 (value 16); o_done 1 cycle later.
REQ-035 i_ready toggled 1-0 each cycle -> all 784 pixels arrive in order, with no gaps in value and no duplicates; outputs stay stable during each stall.
REQ-036 i_ready=0 for 50 cycles at pixel 29 -> o_mem_en stays low after 2 outstanding reads; pixel 29 is held with o_row=1 and o_col=0.
REQ-037 Reset asserted at pixel 400 -> all outputs read 0 next cycle; a new i_start restarts from address 0 with pixel value 1.
REQ-038 i_start pulsed during RUN -> ignored; exactly one o_done per frame; back-to-back start immediately after DONE is accepted.

Source files
------------

// File: rtl/pixel_streamer_pkg.sv
//============================================================================
// Module      : pixel_streamer_pkg
// Description : Shared CNN front-end definitions: default image geometry,
//               pixel width and the pixel streamer control states.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

package pixel_streamer_pkg;

    // Default pixel width and image geometry used by the CNN front end
    localparam int c_DEF_I_F_BW = 8;
    localparam int c_DEF_IX     = 28;
    localparam int c_DEF_IY     = 28;

    // Frame streaming control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
//============================================================================
// Module      : pixel_skid_fifo
// Description : Two-entry FIFO that absorbs the one-cycle memory read
//               latency against downstream back-pressure. A read while full
//               frees a slot for a same-cycle write.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module pixel_skid_fifo
    import pixel_streamer_pkg::*;
#(
    parameter int WIDTH = c_DEF_I_F_BW
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty   = (r_count == 2'd0);
    assign o_full    = (r_count == 2'd2);
    assign o_rd_data = r_mem[r_rd_ptr];

    // The read retires first, so a full FIFO still accepts a write when popped
    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    // Storage, pointers and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_streamer.sv
//============================================================================
// Module      : pixel_streamer
// Description : Reads an IX x IY image from a 1-cycle-latency memory in
//               row-major order and streams it as a valid/ready pixel
//               stream tagged with row, column and last-pixel markers.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int I_F_BW = c_DEF_I_F_BW,
    parameter int IX     = c_DEF_IX,
    parameter int IY     = c_DEF_IY
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_mem_en,
    output logic [$clog2(IX*IY)-1:0]   o_mem_addr,
    input  logic [I_F_BW-1:0]          i_mem_data,
    output logic                       o_valid,
    output logic [I_F_BW-1:0]          o_pixel,
    input  logic                       i_ready,
    output logic [$clog2(IY)-1:0]      o_row,
    output logic [$clog2(IX)-1:0]      o_col,
    output logic                       o_last
);

    localparam int c_NPIX   = IX * IY;
    localparam int c_ADDR_W = $clog2(c_NPIX);
    localparam int c_ROW_W  = $clog2(IY);
    localparam int c_COL_W  = $clog2(IX);

    localparam logic [c_ADDR_W-1:0] c_ADDR_MAX = c_ADDR_W'(c_NPIX - 1);
    localparam logic [c_ROW_W-1:0]  c_ROW_MAX  = c_ROW_W'(IY - 1);
    localparam logic [c_COL_W-1:0]  c_COL_MAX  = c_COL_W'(IX - 1);

    stream_state_t       r_state;
    logic                r_busy;
    logic                r_done;
    logic [c_ADDR_W-1:0] r_addr;
    logic                r_rd_pend;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_COL_W-1:0]  r_col;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [I_F_BW-1:0]   w_fifo_head;
    logic                w_valid;
    logic                w_xfer;
    logic                w_last;
    logic                w_start;
    logic                w_issue;
    logic [1:0]          w_occ;
    logic [1:0]          w_load;

    pixel_skid_fifo #(
        .WIDTH (I_F_BW)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr      (r_rd_pend),
        .i_wr_data (i_mem_data),
        .i_rd      (i_ready),
        .o_rd_data (w_fifo_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_valid = !w_fifo_empty;
    assign w_xfer  = w_valid && i_ready;
    assign w_last  = w_valid && (r_row == c_ROW_MAX) && (r_col == c_COL_MAX);
    assign w_start = (r_state == ST_IDLE) && i_start;

    // FIFO occupancy as a count, derived from the full/empty flags
    always_comb begin
        w_occ = 2'd0;
        if (w_fifo_full) begin
            w_occ = 2'd2;
        end else if (!w_fifo_empty) begin
            w_occ = 2'd1;
        end
    end

    // Reads in flight plus buffered pixels, crediting a pop in this cycle so
    // an unstalled stream sustains one read per cycle without overflowing
    assign w_load  = w_occ + {1'b0, r_rd_pend} - {1'b0, w_xfer};
    assign w_issue = !reset && (r_state == ST_RUN) && (w_load < 2'd2);

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mem_en   = w_issue;
    assign o_mem_addr = r_addr;
    assign o_valid    = w_valid;
    assign o_pixel    = w_fifo_head;
    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_last     = w_last;

    // Frame control FSM with registered busy/done flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_issue && (r_addr == c_ADDR_MAX)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer && w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read address, read-return tracking and output pixel coordinates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_rd_pend <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            r_rd_pend <= w_issue;
            if (w_start) begin
                r_addr <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else begin
                if (w_issue) begin
                    r_addr <= (r_addr == c_ADDR_MAX) ? '0 : r_addr + 1'b1;
                end
                if (w_xfer) begin
                    if (r_col == c_COL_MAX) begin
                        r_col <= '0;
                        r_row <= (r_row == c_ROW_MAX) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_streamer.sv
//============================================================================
// Module      : tb_pixel_streamer
// Description : Scoreboard bench for pixel_streamer: a reference frame
//               model fills an expected queue, a monitor checks every
//               handshake, stall stability and the done pulse.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pixel_streamer;

    localparam int BW   = 8;
    localparam int IX   = 28;
    localparam int IY   = 28;
    localparam int NPIX = IX * IY;
    localparam int AW   = $clog2(NPIX);
    localparam int RW   = $clog2(IY);
    localparam int CW   = $clog2(IX);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_start = 1'b0;
    logic          i_ready = 1'b1;
    logic [BW-1:0] i_mem_data = '0;
    logic          o_busy, o_done, o_mem_en, o_valid, o_last;
    logic [AW-1:0] o_mem_addr;
    logic [BW-1:0] o_pixel;
    logic [RW-1:0] o_row;
    logic [CW-1:0] o_col;

    pixel_streamer #(
        .I_F_BW (BW),
        .IX     (IX),
        .IY     (IY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_mem_en   (o_mem_en),
        .o_mem_addr (o_mem_addr),
        .i_mem_data (i_mem_data),
        .o_valid    (o_valid),
        .o_pixel    (o_pixel),
        .i_ready    (i_ready),
        .o_row      (o_row),
        .o_col      (o_col),
        .o_last     (o_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] pix;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          last;
        int            idx;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] mem [NPIX];

    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_count = 0;
    int   done_cnt = 0;
    int   men_cnt  = 0;
    int   cyc      = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    int   rdy_mode  = 0;
    int   stall_at  = -1;
    int   stall_left = 0;
    bit   exp_done  = 1'b0;
    bit   prev_stall = 1'b0;
    logic [63:0] prev_snap = '0;

    // Image memory: data appears one cycle after the read enable
    always @(posedge clk) begin
        if (o_mem_en) i_mem_data <= mem[o_mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: row-major walk, coordinates from plain division
    task automatic load_frame(input bit rnd);
        exp_t e;
        for (int k = 0; k < NPIX; k++) begin
            mem[k] = rnd ? BW'($urandom) : BW'((k + 1) % 256);
            e.pix  = mem[k];
            e.row  = RW'(k / IX);
            e.col  = CW'(k % IX);
            e.last = (k == NPIX - 1);
            e.idx  = k;
            sb.push_back(e);
        end
    endtask

    task automatic start_frame(input bit chk_lat);
        @(posedge clk); #1 i_start = 1'b1;
        @(negedge clk); #1;
        check("idle_before_start", {o_busy, o_done, o_valid}, 64'd0);
        @(posedge clk); #1 i_start = 1'b0;
        if (chk_lat) begin
            @(negedge clk); #1;
            check("first_read_s1", {o_mem_en, o_busy, o_mem_addr}, {1'b1, 1'b1, AW'(0)});
            @(negedge clk); #1;
            check("no_valid_s2", o_valid, 64'd0);
            @(negedge clk); #1;
            check("first_valid_s3", {o_valid, o_pixel}, {1'b1, mem[0]});
        end
    endtask

    task automatic wait_done(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < NPIX * 4 + 200; i++) begin
            @(negedge clk); #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", ok, 64'd1);
        check("busy_with_done", {o_busy, o_done}, 64'b11);
    endtask

    task automatic wait_hs(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < NPIX * 4; i++) begin
            @(negedge clk); #1;
            if (hs_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("hs_reached", ok, 64'd1);
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: i_ready = 1'b1;
                1: i_ready = ~i_ready;
                2: i_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (hs_count == stall_at && stall_left > 0) begin
                        i_ready = 1'b0;
                        stall_left--;
                    end else begin
                        i_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: scoreboard pops on handshakes, stall hold and done timing
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_stall = 1'b0;
                exp_done   = 1'b0;
                continue;
            end
            if (o_mem_en) men_cnt++;
            if (o_done || exp_done) check("done_pulse", o_done, exp_done);
            if (o_done) done_cnt++;
            exp_done = 1'b0;
            if (prev_stall) check("stall_hold", {o_valid, o_pixel, o_row, o_col, o_last}, prev_snap);
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pixel", {o_pixel, o_row, o_col}, 64'd0 - 64'd1);
                end else begin
                    e = sb.pop_front();
                    check("pixel", {o_pixel, o_row, o_col, o_last}, {e.pix, e.row, e.col, e.last});
                    if (e.idx == 0) first_cyc = cyc;
                    if (e.last) begin
                        last_cyc = cyc;
                        exp_done = 1'b1;
                    end
                end
                hs_count++;
            end
            prev_stall = o_valid && !i_ready;
            prev_snap  = {o_valid, o_pixel, o_row, o_col, o_last};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int m0;
        bit hit;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs", {o_busy, o_done, o_mem_en, o_valid, o_last, o_mem_addr, o_pixel, o_row, o_col}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        check("idle_outputs", {o_busy, o_done, o_mem_en, o_valid, o_last, o_mem_addr, o_pixel, o_row, o_col}, 64'd0);

        // Frame 1: ramp data, always ready -> latency and full throughput
        rdy_mode = 0;
        load_frame(1'b0);
        start_frame(1'b1);
        wait_done(1);
        check("throughput", last_cyc - first_cyc + 1, NPIX);

        // Frame 2: ready alternating every cycle
        rdy_mode = 1;
        load_frame(1'b0);
        start_frame(1'b0);
        wait_done(2);

        // Frame 3: 50-cycle stall with pixel 29 at the head
        base       = hs_count;
        stall_at   = base + 28;
        stall_left = 50;
        rdy_mode   = 3;
        load_frame(1'b0);
        start_frame(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (hs_count == stall_at && !i_ready) begin
                hit = 1'b1;
                break;
            end
        end
        check("stall_reached", hit, 64'd1);
        m0 = men_cnt;
        check("stall_head", {o_valid, o_pixel, o_row, o_col}, {1'b1, 8'd29, RW'(1), CW'(0)});
        repeat (40) @(negedge clk);
        #1;
        check("stall_no_reads", men_cnt - m0, 64'd0);
        check("stall_still_head", {o_valid, o_pixel, o_row, o_col}, {1'b1, 8'd29, RW'(1), CW'(0)});
        wait_done(3);

        // Frame 4: random data, random ready, start pulsed mid-frame
        rdy_mode = 2;
        base = hs_count;
        load_frame(1'b1);
        start_frame(1'b0);
        wait_hs(base + 100);
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        @(negedge clk); #1;
        check("busy_mid_frame", o_busy, 64'd1);
        wait_done(4);

        // Frame 5: started in the first idle cycle after done
        load_frame(1'b1);
        start_frame(1'b1);
        wait_done(5);
        repeat (20) @(negedge clk);
        #1;
        check("one_done_per_frame", done_cnt, 64'd5);
        check("idle_after_frames", {o_busy, o_valid}, 64'd0);
        check("queue_drained", sb.size(), 64'd0);

        // Frame 6: reset while pixel 400 is presented, then restart
        rdy_mode = 0;
        base = hs_count;
        load_frame(1'b0);
        start_frame(1'b0);
        wait_hs(base + 399);
        @(posedge clk); #1 reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk); #1;
        check("abort_outputs", {o_busy, o_done, o_mem_en, o_valid, o_last, o_mem_addr, o_pixel, o_row, o_col}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        check("abort_idle", {o_busy, o_valid, o_mem_addr}, 64'd0);
        load_frame(1'b0);
        start_frame(1'b1);
        wait_done(6);
        check("throughput_after_reset", last_cyc - first_cyc + 1, NPIX);

        repeat (10) @(negedge clk);
        #1;
        check("final_queue_empty", sb.size(), 64'd0);
        check("final_done_count", done_cnt, 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
